// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V pipeline stages.
// Holds the ALU operation encodings, forwarding selects, writeback
// source selects and branch funct3 values, so that the decoder,
// hazard unit and execute stage all agree on one encoding.
package riscv_pkg;

    // ALU operation select (ALUControl)
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    // Operand forwarding select from the hazard unit
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Writeback result source
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    // Branch funct3 encodings
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage.
// Ports:
//   a, b    : operands
//   ctrl    : operation select (ALU_* encodings)
//   result  : selected operation result, modulo 2^XLEN
//   zero    : a equals b
//   lt      : a < b, signed
//   ltu     : a < b, unsigned
// The flags come straight from comparing the operands rather than from
// the selected result, so they are valid for branches regardless of which
// operation is driving result.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            ltu
);

    always_comb begin
        zero = (a == b);
        lt   = ($signed(a) < $signed(b));
        ltu  = (a < b);
    end

    always_comb begin
        result = '0;
        unique case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            ALU_SLL:  result = a << b[4:0];
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RISC-V pipeline.
// Applies forwarding to both source operands, runs the ALU, resolves
// branches / jal / jalr into a same-cycle PC redirect, and registers the
// results into the EX/MEM pipeline register.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   RD1_E, RD2_E, ImmExtE         : operands and immediate from ID/EX
//   PCE, PCPlus4E, InstrE, RdE    : instruction context from ID/EX
//   RegWriteE..ALUSrcE            : control from ID/EX
//   ALUControlE, ResultSrcE       : ALU op and writeback source
//   ForwardAE, ForwardBE          : forwarding selects from hazard unit
//   ALUResultM_fwd, ResultW       : forwarded values from MEM and WB
//   PCSrcE, PCTargetE             : combinational redirect to fetch
//   *M outputs                    : EX/MEM register contents
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC_PLUS4 = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [31:0]     InstrE,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            jalrE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ResultSrcE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM_fwd,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [31:0]     InstrM
);

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;
    logic            lt_e;
    logic            ltu_e;
    logic [2:0]      funct3_e;
    logic            branch_cond_e;
    logic [XLEN-1:0] jalr_sum_e;

    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [XLEN-1:0] write_data_d, write_data_q;
    logic [4:0]      rd_d, rd_q;
    logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
    logic            reg_write_d, reg_write_q;
    logic            mem_write_d, mem_write_q;
    logic [1:0]      result_src_d, result_src_q;
    logic [31:0]     instr_d, instr_q;

    // Forwarding muxes; the reserved select 11 falls back to the register value.
    always_comb begin
        unique case (ForwardAE)
            FWD_WB:  src_a_e = ResultW;
            FWD_MEM: src_a_e = ALUResultM_fwd;
            default: src_a_e = RD1_E;
        endcase
        unique case (ForwardBE)
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = ALUResultM_fwd;
            default: write_data_e = RD2_E;
        endcase
        src_b_e = ALUSrcE ? ImmExtE : write_data_e;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a      (src_a_e),
        .b      (src_b_e),
        .ctrl   (ALUControlE),
        .result (alu_result_e),
        .zero   (zero_e),
        .lt     (lt_e),
        .ltu    (ltu_e)
    );

    // Branch resolution; funct3 010/011 are not branches and never redirect.
    always_comb begin
        funct3_e = InstrE[14:12];
        unique case (funct3_e)
            BR_BEQ:  branch_cond_e = zero_e;
            BR_BNE:  branch_cond_e = !zero_e;
            BR_BLT:  branch_cond_e = lt_e;
            BR_BGE:  branch_cond_e = !lt_e;
            BR_BLTU: branch_cond_e = ltu_e;
            BR_BGEU: branch_cond_e = !ltu_e;
            default: branch_cond_e = 1'b0;
        endcase
        PCSrcE = JumpE | jalrE | (BranchE & branch_cond_e);
    end

    // Dedicated target adder so the redirect never waits on the ALU mux.
    // jalr wins over the PC-relative target when both could apply.
    always_comb begin
        jalr_sum_e = src_a_e + ImmExtE;
        if (jalrE)
            PCTargetE = {jalr_sum_e[XLEN-1:1], 1'b0};
        else
            PCTargetE = PCE + ImmExtE;
    end

    always_comb begin
        alu_result_d = alu_result_e;
        write_data_d = write_data_e;
        rd_d         = RdE;
        pc_plus4_d   = PCPlus4E;
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        instr_d      = InstrE;
    end

    // EX/MEM register. Reset clears MemWrite immediately so an in-flight
    // store can never reach memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= RESET_PC_PLUS4;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            instr_q      <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            instr_q      <= instr_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RdM        = rd_q;
    assign PCPlus4M   = pc_plus4_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign InstrM     = instr_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle. Stimulus is driven on the falling
// edge; the redirect outputs are checked against a reference model shortly
// after, and the expected EX/MEM contents are queued for a monitor that
// checks them just after the next rising edge.
module tb_execute_cycle;

    localparam logic [31:0] RST_PC4 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E, InstrE;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE, JumpE, jalrE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [31:0] ALUResultM_fwd, ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M, InstrM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rd1, rd2, imm, pc, pc4, instr, mfwd, resw;
        logic [4:0]  rd;
        logic        rw, mw, jump, jalr, branch, alusrc;
        logic [2:0]  aluctl;
        logic [1:0]  rsrc, fa, fb;
    } txn_t;

    typedef struct {
        logic [31:0] alu, wd, pc4, instr;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rsrc;
    } mexp_t;

    mexp_t exp_q[$];

    execute_cycle #(.XLEN(32), .RESET_PC_PLUS4(RST_PC4)) dut (
        .clk(clk), .rst(rst),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .ImmExtE(ImmExtE), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .InstrE(InstrE), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .jalrE(jalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM_fwd(ALUResultM_fwd), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM),
        .PCPlus4M(PCPlus4M), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .InstrM(InstrM)
    );

    always #5 clk = ~clk;

    // Reference model: operand selection by name, arithmetic in plain SV.
    function automatic logic [31:0] fwdPick(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] w, input logic [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return r;
    endfunction

    function automatic logic [31:0] opA(input txn_t t);
        return fwdPick(t.fa, t.rd1, t.resw, t.mfwd);
    endfunction

    function automatic logic [31:0] opStore(input txn_t t);
        return fwdPick(t.fb, t.rd2, t.resw, t.mfwd);
    endfunction

    function automatic logic [31:0] opB(input txn_t t);
        return t.alusrc ? t.imm : opStore(t);
    endfunction

    function automatic mexp_t modelM(input txn_t t);
        mexp_t e;
        logic [31:0] a, b;
        a = opA(t);
        b = opB(t);
        case (t.aluctl)
            3'd0: e.alu = a + b;
            3'd1: e.alu = a - b;
            3'd2: e.alu = a & b;
            3'd3: e.alu = a | b;
            3'd4: e.alu = a ^ b;
            3'd5: e.alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: e.alu = (a < b) ? 32'd1 : 32'd0;
            default: e.alu = a << b[4:0];
        endcase
        e.wd = opStore(t);
        e.pc4 = t.pc4;
        e.instr = t.instr;
        e.rd = t.rd;
        e.rw = t.rw;
        e.mw = t.mw;
        e.rsrc = t.rsrc;
        return e;
    endfunction

    function automatic logic modelTaken(input txn_t t);
        logic [31:0] a, b;
        a = opA(t);
        b = opB(t);
        case (t.instr[14:12])
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] modelTarget(input txn_t t);
        if (t.jalr) return (opA(t) + t.imm) & 32'hFFFF_FFFE;
        return t.pc + t.imm;
    endfunction

    function automatic txn_t blankTxn();
        txn_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic txn_t randomTxn();
        txn_t t;
        t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
        t.pc = $urandom; t.pc4 = $urandom; t.instr = $urandom;
        t.mfwd = $urandom; t.resw = $urandom;
        t.rd = 5'($urandom); t.rw = 1'($urandom); t.mw = 1'($urandom);
        t.jump = ($urandom_range(0, 7) == 0);
        t.jalr = ($urandom_range(0, 7) == 0);
        t.branch = 1'($urandom);
        t.alusrc = 1'($urandom);
        t.aluctl = 3'($urandom);
        t.rsrc = 2'($urandom); t.fa = 2'($urandom); t.fb = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            t.rd2 = t.rd1; t.fa = 2'b00; t.fb = 2'b00; t.alusrc = 1'b0;
        end
        if (t.branch) t.aluctl = 3'b001;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        RD1_E = t.rd1; RD2_E = t.rd2; ImmExtE = t.imm; PCE = t.pc;
        PCPlus4E = t.pc4; InstrE = t.instr; RdE = t.rd;
        RegWriteE = t.rw; MemWriteE = t.mw; JumpE = t.jump; jalrE = t.jalr;
        BranchE = t.branch; ALUSrcE = t.alusrc; ALUControlE = t.aluctl;
        ResultSrcE = t.rsrc; ForwardAE = t.fa; ForwardBE = t.fb;
        ALUResultM_fwd = t.mfwd; ResultW = t.resw;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Drives one instruction, checks the redirect, queues the EX/MEM result.
    task automatic applyStimulus(input txn_t t);
        @(negedge clk);
        drive(t);
        #1;
        checkOutput("PCSrcE", {31'b0, PCSrcE}, {31'b0, (t.jump | t.jalr | (t.branch & modelTaken(t)))});
        checkOutput("PCTargetE", PCTargetE, modelTarget(t));
        exp_q.push_back(modelM(t));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ALUResultM"}, ALUResultM, 32'h0);
        checkOutput({tag, "_WriteDataM"}, WriteDataM, 32'h0);
        checkOutput({tag, "_RdM"}, {27'b0, RdM}, 32'h0);
        checkOutput({tag, "_PCPlus4M"}, PCPlus4M, RST_PC4);
        checkOutput({tag, "_RegWriteM"}, {31'b0, RegWriteM}, 32'h0);
        checkOutput({tag, "_MemWriteM"}, {31'b0, MemWriteM}, 32'h0);
        checkOutput({tag, "_ResultSrcM"}, {30'b0, ResultSrcM}, 32'h0);
        checkOutput({tag, "_InstrM"}, InstrM, 32'h0);
    endtask

    // Monitor: pops one expectation per rising edge while out of reset.
    initial begin
        mexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("ALUResultM", ALUResultM, e.alu);
                checkOutput("WriteDataM", WriteDataM, e.wd);
                checkOutput("RdM", {27'b0, RdM}, {27'b0, e.rd});
                checkOutput("PCPlus4M", PCPlus4M, e.pc4);
                checkOutput("RegWriteM", {31'b0, RegWriteM}, {31'b0, e.rw});
                checkOutput("MemWriteM", {31'b0, MemWriteM}, {31'b0, e.mw});
                checkOutput("ResultSrcM", {30'b0, ResultSrcM}, {30'b0, e.rsrc});
                checkOutput("InstrM", InstrM, e.instr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t t;
        drive(randomTxn());

        // Reset held for three cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(randomTxn());
            #1;
            checkReset("reset");
        end
        rst = 1'b0;

        // Simple add after reset.
        t = blankTxn(); t.rd1 = 32'd5; t.rd2 = 32'd7; t.aluctl = 3'b000;
        applyStimulus(t);

        // Forwarding from MEM on A and WB on B, subtract.
        t = blankTxn(); t.fa = 2'b10; t.mfwd = 32'd100; t.fb = 2'b01; t.resw = 32'd3;
        t.rd1 = 32'hAAAA; t.rd2 = 32'h5555; t.aluctl = 3'b001;
        applyStimulus(t);

        // Branches: beq taken, bne not taken, blt taken, bltu not taken.
        t = blankTxn(); t.pc = 32'h40; t.imm = 32'hFFFF_FFF8; t.rd1 = 32'd9; t.rd2 = 32'd9;
        t.branch = 1'b1; t.aluctl = 3'b001; t.instr = 32'h0000_0063;
        applyStimulus(t);
        t.instr = 32'h0000_1063;
        applyStimulus(t);
        t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1; t.instr = 32'h0000_4063;
        applyStimulus(t);
        t.instr = 32'h0000_6063;
        applyStimulus(t);

        // jalr with odd target, plus jalr together with a taken branch.
        t = blankTxn(); t.jalr = 1'b1; t.rd1 = 32'h1003; t.imm = 32'd4; t.rd = 5'd1;
        t.pc4 = 32'h20; t.rw = 1'b1; t.rsrc = 2'b10; t.pc = 32'h200;
        applyStimulus(t);
        t.branch = 1'b1; t.jump = 1'b1; t.aluctl = 3'b001;
        applyStimulus(t);

        // Bubble: all-zero control.
        applyStimulus(blankTxn());

        // Store followed by an asynchronous reset between edges.
        t = blankTxn(); t.mw = 1'b1; t.alusrc = 1'b1; t.rd1 = 32'h100; t.imm = 32'd8;
        t.rd2 = 32'hDEAD; t.aluctl = 3'b000;
        applyStimulus(t);
        @(posedge clk);
        #2;
        checkOutput("store_MemWriteM", {31'b0, MemWriteM}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkReset("midreset");
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) applyStimulus(randomTxn());

        repeat (3) @(posedge clk);
        #2;
        checkOutput("drain", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
